// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter.
// FSM state enum, ALU op codes, flag bit positions and datapath widths.
package alu_arb_pkg;

  localparam int DATA_W  = 8;
  localparam int FLAGS_W = 5;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;

  // Bit positions inside the {parity, overflow, greater, is_eq, less} flag bus.
  localparam int PAR = 4;
  localparam int OVF = 3;
  localparam int GT  = 2;
  localparam int EQ  = 1;
  localparam int LT  = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// The search starts at ptr_i+1 and wraps modulo NREQ; the first requester
// found wins. With no request pending, grant_o is all zeros and grant_idx_o is 0.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  grant_idx_o
);

  logic [IDW-1:0] idx;

  // Scan from the farthest candidate back to ptr+1 so the nearest one is written last and wins.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    idx         = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IDW'((int'(ptr_i) + k) % NREQ);
      if (req_i[idx]) begin
        grant_o      = '0;
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one external 8-bit combinational ALU among NREQ requesters.
// Flow: IDLE (grant + accept, operands registered) -> EXEC (alu_oe high, ALU
// outputs captured at the end of the cycle) -> RESP (result held until accepted).
// Optional feature: define ALU_ARB_FLAGS_EN to capture alu_flags into
// resp_flags. Without it, resp_flags is tied to zero and alu_flags is ignored.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. A source keeps valid and its payload stable until then.
// Request side: req_valid[i] is paired with req_ready[i], and at most one ready
// bit is high. Response side: resp_valid is paired with resp_ready, and
// resp_id/resp_y/resp_flags do not change while resp_valid is waiting.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  input  logic [NREQ*2-1:0]      req_op,
  output logic [DATA_W-1:0]      alu_a,
  output logic [DATA_W-1:0]      alu_b,
  output logic [1:0]             alu_op,
  output logic                   alu_oe,
  input  logic [DATA_W-1:0]      alu_y,
  input  logic [FLAGS_W-1:0]     alu_flags,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [IDW-1:0]         resp_id,
  output logic [DATA_W-1:0]      resp_y,
  output logic [FLAGS_W-1:0]     resp_flags,
  output logic [15:0]            done_cnt,
  output state_e                 dbg_state
);

  state_e              state_q;
  logic [IDW-1:0]      ptr_q;
  logic [IDW-1:0]      id_q;
  logic [DATA_W-1:0]   a_q, b_q, y_q;
  logic [1:0]          op_q;
  logic                oe_q;
  logic                rv_q;
  logic [15:0]         done_q;

  logic [NREQ-1:0]     grant;
  logic [IDW-1:0]      grant_idx;
  logic                accept;
  logic [DATA_W-1:0]   a_d, b_d;
  logic [1:0]          op_d;
  logic [15:0]         done_d;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req_i       (req_valid),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  // Offer the grant only while idle and out of reset; select the winner's payload.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && !rst) begin
      req_ready = grant;
    end
    accept = |(req_valid & req_ready);
    a_d    = req_a[int'(grant_idx) * DATA_W +: DATA_W];
    b_d    = req_b[int'(grant_idx) * DATA_W +: DATA_W];
    op_d   = req_op[int'(grant_idx) * 2 +: 2];
    done_d = done_q + 16'd1;
  end

  // Main FSM; alu_oe and resp_valid are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= IDW'(NREQ - 1);
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      y_q     <= '0;
      oe_q    <= 1'b0;
      rv_q    <= 1'b0;
      done_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            id_q    <= grant_idx;
            ptr_q   <= grant_idx;
            oe_q    <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          y_q     <= alu_y;
          oe_q    <= 1'b0;
          rv_q    <= 1'b1;
          state_q <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            rv_q    <= 1'b0;
            done_q  <= done_d;
            state_q <= IDLE;
          end
        end
        default: begin
          oe_q    <= 1'b0;
          rv_q    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_ARB_FLAGS_EN
  logic [FLAGS_W-1:0] flags_q;

  // Capture the ALU flags in the same cycle as the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
    end else if (state_q == EXEC) begin
      flags_q <= alu_flags;
    end
  end

  assign resp_flags = flags_q;
`else
  logic unused_flags;
  assign unused_flags = ^alu_flags;
  assign resp_flags   = '0;
`endif

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign alu_oe     = oe_q;
  assign resp_valid = rv_q;
  assign resp_id    = id_q;
  assign resp_y     = y_q;
  assign done_cnt   = done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed steps, a stand-in ALU and an
// expected-response queue. Honours ALU_ARB_FLAGS_EN in the same way as the RTL.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int EW   = IDW + DATA_W + FLAGS_W;
`ifdef ALU_ARB_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic                   clk;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*DATA_W-1:0] req_a, req_b;
  logic [NREQ*2-1:0]      req_op;
  logic [DATA_W-1:0]      alu_a, alu_b, alu_y;
  logic [1:0]             alu_op;
  logic                   alu_oe;
  logic [FLAGS_W-1:0]     alu_flags;
  logic                   resp_valid, resp_ready;
  logic [IDW-1:0]         resp_id;
  logic [DATA_W-1:0]      resp_y;
  logic [FLAGS_W-1:0]     resp_flags;
  logic [15:0]            done_cnt;
  state_e                 dbg_state;

  int tests = 0;
  int fails = 0;

  logic [EW-1:0] exp_q[$];
  logic [7:0]    pl_a[NREQ];
  logic [7:0]    pl_b[NREQ];
  logic [1:0]    pl_op[NREQ];
  logic [12:0]   alu_full;

  alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_oe     (alu_oe),
    .alu_y      (alu_y),
    .alu_flags  (alu_flags),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_y     (resp_y),
    .resp_flags (resp_flags),
    .done_cnt   (done_cnt),
    .dbg_state  (dbg_state)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference ALU: returns {y, parity, overflow, greater, is_eq, less}.
  function automatic logic [12:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [1:0] op);
    logic [7:0] y;
    logic       ovf;
    case (op)
      2'b00:   begin y = a + b; ovf = (a[7] == b[7]) && (y[7] != a[7]); end
      2'b01:   begin y = a - b; ovf = (a[7] != b[7]) && (y[7] != a[7]); end
      2'b10:   begin y = a & b; ovf = 1'b0; end
      default: begin y = a | b; ovf = 1'b0; end
    endcase
    return {y, ^y, ovf, a > b, a == b, a < b};
  endfunction

  // External ALU stand-in; outputs a recognisable junk pattern when not enabled.
  always_comb begin
    alu_full = alu_model(alu_a, alu_b, alu_op);
    if (alu_oe) begin
      alu_y     = alu_full[12:5];
      alu_flags = alu_full[4:0];
    end else begin
      alu_y     = 8'hEE;
      alu_flags = 5'h15;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] op);
    pl_a[i]            = a;
    pl_b[i]            = b;
    pl_op[i]           = op;
    req_a[i*8 +: 8]    = a;
    req_b[i*8 +: 8]    = b;
    req_op[i*2 +: 2]   = op;
    req_valid[i]       = 1'b1;
  endtask

  task automatic set_req_rand(input int i);
    set_req(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            2'($urandom_range(0, 3)));
  endtask

  task automatic push_exp(input int i);
    logic [12:0]        r;
    logic [FLAGS_W-1:0] f;
    r = alu_model(pl_a[i], pl_b[i], pl_op[i]);
    f = FLAGS_ON ? r[4:0] : '0;
    exp_q.push_back({IDW'(i), r[12:5], f});
  endtask

  task automatic check_resp(input string tag, input bit pop);
    logic [EW-1:0] e;
    chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      e = exp_q[0];
      chk({tag, "_id"},    32'(resp_id),    32'(e[EW-1 -: IDW]));
      chk({tag, "_y"},     32'(resp_y),     32'(e[FLAGS_W +: DATA_W]));
      chk({tag, "_flags"}, 32'(resp_flags), 32'(e[FLAGS_W-1:0]));
      if (pop) void'(exp_q.pop_front());
    end
  endtask

  // Full transaction with resp_ready high: grant, accept, EXEC, RESP, retire.
  task automatic run_txn(input string tag, input int i, input logic [7:0] a,
                         input logic [7:0] b, input logic [1:0] op);
    set_req(i, a, b, op);
    resp_ready = 1'b1;
    settle();
    chk({tag, "_grant"}, 32'(req_ready), 32'd1 << i);
    push_exp(i);
    tick();
    req_valid[i] = 1'b0;
    settle();
    chk({tag, "_oe"}, 32'(alu_oe), 32'd1);
    tick();
    settle();
    check_resp(tag, 1'b1);
    tick();
    settle();
  endtask

  // Directed sequence
  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    resp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      pl_a[i] = '0; pl_b[i] = '0; pl_op[i] = '0;
    end

    // Reset values, with every requester asking so the ready gating is exercised.
    req_valid = '1;
    tick();
    tick();
    settle();
    chk("rst_ready",   32'(req_ready),  32'd0);
    chk("rst_alu_a",   32'(alu_a),      32'd0);
    chk("rst_alu_b",   32'(alu_b),      32'd0);
    chk("rst_alu_op",  32'(alu_op),     32'd0);
    chk("rst_alu_oe",  32'(alu_oe),     32'd0);
    chk("rst_rvalid",  32'(resp_valid), 32'd0);
    chk("rst_rid",     32'(resp_id),    32'd0);
    chk("rst_ry",      32'(resp_y),     32'd0);
    chk("rst_rflags",  32'(resp_flags), 32'd0);
    chk("rst_done",    32'(done_cnt),   32'd0);
    chk("rst_state",   32'(dbg_state),  32'(IDLE));
    req_valid = '0;
    rst       = 1'b0;

    // Requester 2 alone: 5 + 3.
    tick();
    set_req(2, 8'h05, 8'h03, ALU_ADD);
    settle();
    chk("t1_ready", 32'(req_ready), 32'h4);
    push_exp(2);
    tick();
    req_valid[2] = 1'b0;
    settle();
    chk("t1_oe",     32'(alu_oe),     32'd1);
    chk("t1_alu_a",  32'(alu_a),      32'h05);
    chk("t1_alu_b",  32'(alu_b),      32'h03);
    chk("t1_alu_op", 32'(alu_op),     32'(ALU_ADD));
    chk("t1_rvalid", 32'(resp_valid), 32'd0);
    tick();
    settle();
    chk("t1_oe_off", 32'(alu_oe), 32'd0);
    chk("t1_y_lit",  32'(resp_y), 32'h08);
    chk("t1_id_lit", 32'(resp_id), 32'd2);
    check_resp("t1", 1'b1);
    resp_ready = 1'b1;
    tick();
    settle();
    chk("t1_rvalid_off", 32'(resp_valid), 32'd0);
    chk("t1_done",       32'(done_cnt),   32'd1);
    chk("t1_state",      32'(dbg_state),  32'(IDLE));

    // All requesters held valid, back-to-back: expect 0,1,2,3,0,1 every 3 cycles.
    rst = 1'b1;
    settle();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req_rand(i);
    settle();
    for (int g = 0; g < 6; g++) begin
      int w;
      w = g % NREQ;
      chk("t2_grant", 32'(req_ready), 32'd1 << w);
      push_exp(w);
      tick();
      set_req_rand(w);
      settle();
      chk("t2_exec_ready", 32'(req_ready), 32'd0);
      chk("t2_exec_oe",    32'(alu_oe),    32'd1);
      tick();
      settle();
      check_resp("t2", 1'b1);
      chk("t2_resp_ready", 32'(req_ready), 32'd0);
      tick();
      settle();
    end
    req_valid = '0;
    settle();
    chk("t2_done", 32'(done_cnt), 32'd6);

    // Response back-pressure for 10 cycles with requester 1 waiting.
    resp_ready = 1'b0;
    set_req_rand(2);
    settle();
    chk("t3_grant2", 32'(req_ready), 32'h4);
    push_exp(2);
    tick();
    req_valid[2] = 1'b0;
    tick();
    set_req_rand(1);
    settle();
    for (int c = 0; c < 10; c++) begin
      check_resp("t3_hold", 1'b0);
      chk("t3_hold_ready", 32'(req_ready), 32'd0);
      chk("t3_hold_state", 32'(dbg_state), 32'(RESP));
      tick();
      settle();
    end
    void'(exp_q.pop_front());
    resp_ready = 1'b1;
    tick();
    settle();
    chk("t3_rvalid_off", 32'(resp_valid), 32'd0);
    chk("t3_grant1",     32'(req_ready),  32'h2);
    push_exp(1);
    tick();
    req_valid[1] = 1'b0;
    tick();
    settle();
    check_resp("t3", 1'b1);
    tick();
    settle();
    chk("t3_done", 32'(done_cnt), 32'd8);

    // Reset while a response is waiting.
    resp_ready = 1'b0;
    set_req_rand(3);
    settle();
    chk("t4_grant3", 32'(req_ready), 32'h8);
    push_exp(3);
    tick();
    req_valid[3] = 1'b0;
    tick();
    settle();
    chk("t4_rvalid_pre", 32'(resp_valid), 32'd1);
    rst = 1'b1;
    settle();
    chk("t4_rvalid", 32'(resp_valid), 32'd0);
    chk("t4_state",  32'(dbg_state),  32'(IDLE));
    chk("t4_ry",     32'(resp_y),     32'd0);
    chk("t4_done",   32'(done_cnt),   32'd0);
    exp_q.delete();
    for (int i = 0; i < NREQ; i++) set_req_rand(i);
    settle();
    chk("t4_rst_ready", 32'(req_ready), 32'd0);
    tick();
    rst = 1'b0;
    settle();
    chk("t4_grant0", 32'(req_ready), 32'h1);
    push_exp(0);
    resp_ready = 1'b1;
    tick();
    req_valid = '0;
    tick();
    settle();
    check_resp("t4", 1'b1);
    tick();
    settle();

    // Flag capture: equal operands, then a subtraction that goes negative.
    run_txn("t5_eq", 1, 8'h7F, 8'h7F, ALU_ADD);
    chk("t5_eq_bit", 32'(resp_flags[EQ]), 32'(FLAGS_ON));
    chk("t5_flags",  32'(resp_flags),     FLAGS_ON ? 32'h1A : 32'h0);
    run_txn("t5_sub", 2, 8'h03, 8'h05, ALU_SUB);
    chk("t5_sub_y",  32'(resp_y),         32'hFE);
    chk("t5_lt_bit", 32'(resp_flags[LT]), 32'(FLAGS_ON));
    chk("t5_done",   32'(done_cnt),       32'd3);

    // Counter wrap from 0xFFFF.
    force dut.done_q = 16'hFFFF;
    #1;
    release dut.done_q;
    settle();
    chk("t6_preset", 32'(done_cnt), 32'hFFFF);
    run_txn("t6", 3, 8'h10, 8'h22, 2'b11);
    chk("t6_wrap", 32'(done_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
